// File: rtl/aux_uart_pkg.sv
// Register map and bit positions for the aux-bus UART FIFO window.
// Shared by aux_uart_fifo and its testbench.
package aux_uart_pkg;

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_STATUS   = 3'd1,
        REG_CTRL     = 3'd2,
        REG_PRESC_LO = 3'd3,
        REG_PRESC_HI = 3'd4
    } reg_e;

    localparam int NUM_REGS = 5;

    localparam int ST_RX_NEMPTY = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_TX_FULL   = 3;
    localparam int ST_RX_OVR    = 4;
    localparam int ST_TX_DROP   = 5;

    localparam int CTRL_RXIE     = 0;
    localparam int CTRL_TXIE     = 1;
    localparam int CTRL_TX_FLUSH = 6;
    localparam int CTRL_RX_FLUSH = 7;

endpackage

// File: rtl/aux_uart_fifo_sync_fifo.sv
// Byte FIFO with separate occupancy count and synchronous flush.
// A pop in the same cycle frees a slot for a push into a full FIFO.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign drop    = push & ~flush & full & ~do_pop;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/aux_uart_fifo.sv
// Five-register aux-bus window in front of the UART stream ports.
// Define AUX_UART_IRQ_EN to build the interrupt flop and CTRL enables.
module aux_uart_fifo
    import aux_uart_pkg::*;
#(
    parameter int                        AUX_ADDR_WIDTH   = 16,
    parameter logic [AUX_ADDR_WIDTH-1:0] BASE_ADDR        = 16'hFF00,
    parameter int                        FIFO_DEPTH_LOG2  = 4,
    parameter logic [15:0]               DEFAULT_PRESCALE = 16'd1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [AUX_ADDR_WIDTH-1:0] aux_adr_i,
    input  logic [7:0]                aux_dat_i,
    output logic [7:0]                aux_dat_o,
    output logic                      aux_sel_o,
    input  logic                      aux_we_i,
    input  logic                      aux_re_i,
    output logic [7:0]                tx_tdata_o,
    output logic                      tx_tvalid_o,
    input  logic                      tx_tready_i,
    input  logic [7:0]                rx_tdata_i,
    input  logic                      rx_tvalid_i,
    output logic                      rx_tready_o,
    output logic [15:0]               prescale_o,
    output logic                      irq_o
);

    logic [AUX_ADDR_WIDTH-1:0] off;
    logic [2:0]                reg_sel;
    logic                      hit;
    logic                      wr;
    logic                      wr_data;
    logic                      wr_status;
    logic                      wr_ctrl;
    logic                      wr_plo;
    logic                      wr_phi;
    logic                      rd_pop;

    logic                      tx_flush;
    logic                      tx_empty;
    logic                      tx_full;
    logic                      tx_drop;
    logic                      tx_pop;
    logic                      rx_flush;
    logic                      rx_empty;
    logic                      rx_full;
    logic                      rx_drop;
    logic [7:0]                rx_head;

    logic                      rx_ovr_q;
    logic                      tx_drop_q;
    logic [15:0]               presc_q;
    logic                      rdy_q;
    logic                      rxie_q;
    logic                      txie_q;
    logic [7:0]                status;
    logic [7:0]                ctrl;
    logic [7:0]                rd_data;

    // Modular offset makes the window test a single compare.
    assign off     = aux_adr_i - BASE_ADDR;
    assign hit     = (off < AUX_ADDR_WIDTH'(NUM_REGS));
    assign reg_sel = off[2:0];

    assign wr        = hit & aux_we_i;
    assign wr_data   = wr & (reg_sel == REG_DATA);
    assign wr_status = wr & (reg_sel == REG_STATUS);
    assign wr_ctrl   = wr & (reg_sel == REG_CTRL);
    assign wr_plo    = wr & (reg_sel == REG_PRESC_LO);
    assign wr_phi    = wr & (reg_sel == REG_PRESC_HI);
    assign rd_pop    = hit & aux_re_i & (reg_sel == REG_DATA);

    assign tx_flush = wr_ctrl & aux_dat_i[CTRL_TX_FLUSH];
    assign rx_flush = wr_ctrl & aux_dat_i[CTRL_RX_FLUSH];
    assign tx_pop   = tx_tvalid_o & tx_tready_i;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (tx_flush),
        .push    (wr_data),
        .wdata   (aux_dat_i),
        .pop     (tx_pop),
        .rdata   (tx_tdata_o),
        .empty   (tx_empty),
        .full    (tx_full),
        .drop    (tx_drop)
    );

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (rx_flush),
        .push    (rx_tvalid_i),
        .wdata   (rx_tdata_i),
        .pop     (rd_pop),
        .rdata   (rx_head),
        .empty   (rx_empty),
        .full    (rx_full),
        .drop    (rx_drop)
    );

    assign tx_tvalid_o = ~tx_empty;
    assign rx_tready_o = rdy_q;
    assign prescale_o  = presc_q;

    // A new drop event outranks a clear written in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ovr_q  <= 1'b0;
            tx_drop_q <= 1'b0;
            presc_q   <= DEFAULT_PRESCALE;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (rx_drop) begin
                rx_ovr_q <= 1'b1;
            end else if (wr_status & aux_dat_i[ST_RX_OVR]) begin
                rx_ovr_q <= 1'b0;
            end
            if (tx_drop) begin
                tx_drop_q <= 1'b1;
            end else if (wr_status & aux_dat_i[ST_TX_DROP]) begin
                tx_drop_q <= 1'b0;
            end
            if (wr_plo) begin
                presc_q[7:0] <= aux_dat_i;
            end
            if (wr_phi) begin
                presc_q[15:8] <= aux_dat_i;
            end
        end
    end

`ifdef AUX_UART_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxie_q <= 1'b0;
            txie_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                rxie_q <= aux_dat_i[CTRL_RXIE];
                txie_q <= aux_dat_i[CTRL_TXIE];
            end
            irq_q <= (rxie_q & ~rx_empty)
                   | (txie_q & tx_empty)
                   | rx_ovr_q;
        end
    end

    assign irq_o = irq_q;
`else
    assign rxie_q = 1'b0;
    assign txie_q = 1'b0;
    assign irq_o  = 1'b0;
`endif

    always_comb begin
        status               = '0;
        status[ST_RX_NEMPTY] = ~rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_FULL]   = tx_full;
        status[ST_RX_OVR]    = rx_ovr_q;
        status[ST_TX_DROP]   = tx_drop_q;
    end

    always_comb begin
        ctrl            = '0;
        ctrl[CTRL_RXIE] = rxie_q;
        ctrl[CTRL_TXIE] = txie_q;
    end

    always_comb begin
        rd_data = '0;
        if (hit) begin
            unique case (reg_sel)
                REG_DATA:     rd_data = rx_empty ? 8'h00 : rx_head;
                REG_STATUS:   rd_data = status;
                REG_CTRL:     rd_data = ctrl;
                REG_PRESC_LO: rd_data = presc_q[7:0];
                REG_PRESC_HI: rd_data = presc_q[15:8];
                default:      rd_data = '0;
            endcase
        end
    end

    assign aux_dat_o = rd_data;
    assign aux_sel_o = hit;

endmodule

// File: tb/tb_aux_uart_fifo.sv
// Randomised and directed bench for aux_uart_fifo against a queue model.
// Honours AUX_UART_IRQ_EN the same way the design does.
module tb_aux_uart_fifo;

    localparam int          DEPTH = 16;
    localparam logic [15:0] BASE  = 16'hFF00;
    localparam logic [15:0] DPRE  = 16'd1;
`ifdef AUX_UART_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] adr = 16'h0000;
    logic [7:0]  di = 8'h00;
    logic [7:0]  dout;
    logic        sel;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [7:0]  txd;
    logic        txv;
    logic        txr = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        rxv = 1'b0;
    logic        rxr;
    logic [15:0] presc;
    logic        irq;

    aux_uart_fifo #(
        .AUX_ADDR_WIDTH   (16),
        .BASE_ADDR        (BASE),
        .FIFO_DEPTH_LOG2  (4),
        .DEFAULT_PRESCALE (DPRE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .aux_adr_i   (adr),
        .aux_dat_i   (di),
        .aux_dat_o   (dout),
        .aux_sel_o   (sel),
        .aux_we_i    (we),
        .aux_re_i    (re),
        .tx_tdata_o  (txd),
        .tx_tvalid_o (txv),
        .tx_tready_i (txr),
        .rx_tdata_i  (rxd),
        .rx_tvalid_i (rxv),
        .rx_tready_o (rxr),
        .prescale_o  (presc),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    bit          m_ovr, m_drop, m_rxie, m_txie, m_irq, m_rdy;
    logic [15:0] m_presc;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  obs_dat, obs_txd;
    logic        obs_txv, obs_irq;
    logic [15:0] obs_presc;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        txq.delete();
        rxq.delete();
        m_ovr = 0; m_drop = 0; m_rxie = 0; m_txie = 0;
        m_irq = 0; m_rdy = 0;
        m_presc = DPRE;
    endfunction

    function automatic logic [7:0] m_status();
        return {2'b00, m_drop, m_ovr,
                txq.size() == DEPTH, txq.size() == 0,
                rxq.size() == DEPTH, rxq.size() != 0};
    endfunction

    function automatic logic [7:0] m_read();
        logic [15:0] o;
        o = adr - BASE;
        case (o)
            16'd0:   return (rxq.size() != 0) ? rxq[0] : 8'h00;
            16'd1:   return m_status();
            16'd2:   return {6'b0, m_txie, m_rxie};
            16'd3:   return m_presc[7:0];
            16'd4:   return m_presc[15:8];
            default: return 8'h00;
        endcase
    endfunction

    // Advance the model across one rising edge using the current inputs.
    function automatic void m_step();
        logic [15:0] o;
        bit wr, ovr_set, drop_set, irq_n;
        o = adr - BASE;
        wr = (o < 16'd5) && we;
        ovr_set = 0;
        drop_set = 0;
        irq_n = IRQ_EN && ((m_rxie && rxq.size() != 0) ||
                           (m_txie && txq.size() == 0) || m_ovr);
        if (wr && o == 16'd2 && di[6]) txq.delete();
        else begin
            if (txq.size() != 0 && txr) void'(txq.pop_front());
            if (wr && o == 16'd0) begin
                if (txq.size() < DEPTH) txq.push_back(di);
                else drop_set = 1;
            end
        end
        if (wr && o == 16'd2 && di[7]) rxq.delete();
        else begin
            if (rxq.size() != 0 && re && o == 16'd0) void'(rxq.pop_front());
            if (rxv) begin
                if (rxq.size() < DEPTH) rxq.push_back(rxd);
                else ovr_set = 1;
            end
        end
        if (wr && o == 16'd1) begin
            if (di[4]) m_ovr = 0;
            if (di[5]) m_drop = 0;
        end
        if (ovr_set) m_ovr = 1;
        if (drop_set) m_drop = 1;
        if (IRQ_EN && wr && o == 16'd2) begin
            m_rxie = di[0];
            m_txie = di[1];
        end
        if (wr && o == 16'd3) m_presc[7:0] = di;
        if (wr && o == 16'd4) m_presc[15:8] = di;
        m_irq = irq_n;
        m_rdy = 1;
    endfunction

    task automatic cyc();
        logic [15:0] o;
        #1;
        o = adr - BASE;
        chk("sel", sel, o < 16'd5);
        chk("rdata", dout, m_read());
        chk("txv", txv, txq.size() != 0);
        if (txq.size() != 0) chk("txd", txd, txq[0]);
        chk("presc", presc, m_presc);
        chk("rxready", rxr, m_rdy);
        chk("irq", irq, m_irq);
        obs_dat = dout;
        obs_txd = txd;
        obs_txv = txv;
        obs_irq = irq;
        obs_presc = presc;
        m_step();
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [2:0] o, input logic [7:0] v);
        adr = BASE + 16'(o);
        di = v;
        we = 1;
        cyc();
        we = 0;
        adr = 16'h0000;
    endtask

    task automatic rd_reg(input logic [2:0] o, output logic [7:0] v);
        adr = BASE + 16'(o);
        re = 1;
        cyc();
        re = 0;
        adr = 16'h0000;
        v = obs_dat;
    endtask

    initial begin
        logic [7:0] v;
        logic [15:0] o;
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rxready", rxr, 0);
        chk("rst_txv", txv, 0);
        @(negedge clk);
        reset_n = 1;

        rd_reg(1, v); chk("rst_status", v, 8'h04);
        rd_reg(2, v); chk("rst_ctrl", v, 8'h00);
        rd_reg(3, v); chk("rst_plo", v, DPRE[7:0]);
        rd_reg(4, v); chk("rst_phi", v, DPRE[15:8]);
        chk("rst_irq", obs_irq, 0);

        txr = 0;
        wr_reg(0, 8'h41);
        wr_reg(0, 8'h42);
        txr = 1;
        cyc(); chk("tx_first", {obs_txv, obs_txd}, {1'b1, 8'h41});
        cyc(); chk("tx_second", {obs_txv, obs_txd}, {1'b1, 8'h42});
        rd_reg(1, v); chk("tx_empty_after", v[2], 1);

        rxv = 1;
        for (int i = 0; i < 17; i++) begin
            rxd = 8'(i);
            cyc();
        end
        rxv = 0;
        rd_reg(1, v); chk("ovr_status", v, 8'h17);
        for (int i = 0; i < 16; i++) begin
            rd_reg(0, v); chk("ovr_order", v, 16'(i));
        end
        wr_reg(1, 8'h10);
        rd_reg(1, v); chk("ovr_clear", v, 8'h04);

        rxv = 1;
        for (int i = 0; i < 16; i++) begin
            rxd = 8'h80 + 8'(i);
            cyc();
        end
        rxd = 8'hAA;
        rd_reg(0, v); chk("full_pp_pop", v, 8'h80);
        rxv = 0;
        rd_reg(1, v); chk("full_pp_status", v, 8'h07);
        for (int j = 0; j < 16; j++) begin
            rd_reg(0, v);
            chk("full_pp_order", v, (j < 15) ? 16'(8'h81 + 8'(j)) : 16'hAA);
        end

        wr_reg(3, 8'h34);
        wr_reg(4, 8'h12);
        cyc(); chk("presc_1234", obs_presc, 16'h1234);
        rxv = 1; rxd = 8'h55; cyc(); rxv = 0;
        wr_reg(2, 8'h80);
        rd_reg(1, v); chk("rx_flush", v, 8'h04);

`ifdef AUX_UART_IRQ_EN
        wr_reg(2, 8'h01);
        rxv = 1; rxd = 8'h66; cyc(); rxv = 0;
        cyc(); chk("irq_wait", obs_irq, 0);
        cyc(); chk("irq_set", obs_irq, 1);
        rd_reg(0, v);
        cyc();
        cyc(); chk("irq_clr", obs_irq, 0);
        wr_reg(2, 8'h00);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 8) adr = BASE + 16'($urandom_range(0, 5));
            else adr = 16'($urandom);
            o = adr - BASE;
            we = ($urandom_range(0, 3) == 0);
            re = $urandom_range(0, 1);
            di = 8'($urandom);
            if (o == 16'd2 && $urandom_range(0, 3) != 0) di[7:6] = 2'b00;
            txr = ((i / 400) % 2 == 0) ? ($urandom_range(0, 7) == 0)
                                         : ($urandom_range(0, 1) == 1);
            rxv = ((i / 300) % 2 == 0) ? ($urandom_range(0, 1) == 1)
                                         : ($urandom_range(0, 7) == 0);
            rxd = 8'($urandom);
            cyc();
        end
        we = 0; re = 0; rxv = 0; adr = 16'h0000;

        txr = 0;
        wr_reg(0, 8'h99);
        #2;
        reset_n = 0;
        #1;
        chk("midreset_txv", txv, 0);
        chk("midreset_rxready", rxr, 0);
        m_reset();
        @(negedge clk);
        reset_n = 1;
        rd_reg(1, v); chk("post_rst_status", v, 8'h04);
        rd_reg(3, v); chk("post_rst_plo", v, DPRE[7:0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aux_uart_fifo.md
# aux_uart_fifo

Memory-mapped, FIFO-buffered UART front end for the PIC core's auxiliary bus. It replaces direct byte-level wiring between the core and the `uart` core with a five-register window at a parametrised base address. The window provides TX and RX FIFOs of configurable depth, a runtime-programmable baud prescale, sticky error flags and an optional interrupt. It sits between the core's aux bus (`aux_adr`/`aux_dat`/`aux_we`/`aux_re`) and the AXI-stream side of the existing `uart` instance.

## Interface
- `AUX_ADDR_WIDTH`, 16: aux address width.
- `BASE_ADDR`, 16'hFF00: address of register 0; the window occupies `BASE_ADDR`..`BASE_ADDR+4`.
- `FIFO_DEPTH_LOG2`, 4: each FIFO holds 2^N bytes; legal range 1..8.
- `DEFAULT_PRESCALE`, 16'd1: reset value of the prescale register.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `aux_adr_i`  in  AUX_ADDR_WIDTH: bus address.
- `aux_dat_i`  in  8: write data.
- `aux_dat_o`  out  8: read data, combinational.
- `aux_sel_o`  out  1: address hits the window; the top uses it to mux/tristate the shared bus.
- `aux_we_i`  in  1: write strobe.
- `aux_re_i`  in  1: read strobe.
- `tx_tdata_o`  out  8: byte to the UART.
- `tx_tvalid_o`  out  1: TX FIFO not empty.
- `tx_tready_i`  in  1: UART accepts.
- `rx_tdata_i`  in  8: byte from the UART.
- `rx_tvalid_i`  in  1: UART byte valid.
- `rx_tready_o`  out  1: constant 1 outside reset.
- `prescale_o`  out  16: UART prescale.
- `irq_o`  out  1: registered interrupt request.

## Operation
Register map (offset from `BASE_ADDR`):
- 0 DATA
  - Write: push to TX FIFO.
  - Read: return RX head. With `aux_re_i`, pop at the clock edge.
  - Empty RX: read returns 8'h00 and does not pop.
- 1 STATUS (R)
  - [0] RX_NEMPTY, [1] RX_FULL, [2] TX_EMPTY, [3] TX_FULL.
  - [4] RX_OVR (sticky), [5] TX_DROP (sticky); bits 7:6 read 0.
  - Writing 1 to bit 4 or bit 5 clears that bit.
- 2 CTRL (R/W)
  - [0] RXIE, [1] TXIE.
  - [6] TX_FLUSH and [7] RX_FLUSH are self-clearing and always read 0. A flush empties the FIFO at that edge.
- 3 PRESC_LO, 4 PRESC_HI (R/W): bytes of `prescale_o`.

FIFO rules:
- Pointers are FIFO_DEPTH_LOG2 bits and wrap modulo depth. Occupancy is a separate (FIFO_DEPTH_LOG2+1)-bit count.
- TX push is accepted if not full, or if a TX pop occurs in the same cycle. Otherwise the byte is dropped and TX_DROP is set.
- RX push happens on `rx_tvalid_i`. It is accepted if not full, or if a CPU pop occurs in the same cycle. Otherwise the byte is dropped and RX_OVR is set. The UART is never stalled.
- Simultaneous push and pop on an empty RX FIFO: no pop, push succeeds.
- Simultaneous push and pop on a full FIFO: both succeed and the count stays at full.
- Flush has priority over push in the same cycle.
- `tx_tvalid_o = !tx_empty`; `tx_tdata_o` = TX head. Pop on `tx_tvalid_o & tx_tready_i`.
- Writes and reads outside the window are ignored. `aux_sel_o` = 0 and `aux_dat_o` = 8'h00 outside the window.

Reset values: FIFOs empty, all pointers 0, STATUS sticky bits 0, CTRL 0, `prescale_o` = DEFAULT_PRESCALE, `irq_o` 0, `tx_tvalid_o` 0, `rx_tready_o` 0. Asserting reset mid-transfer discards all FIFO contents immediately.

## Timing
- Register write takes effect at the rising edge where `aux_we_i` is high; the new value is visible on reads in the next cycle.
- DATA read data is valid in the same cycle the address is presented (matches the aux RAM). The pop takes effect at the edge.
- RX byte accepted at edge N is visible as RX_NEMPTY = 1 in cycle N+1.
- TX write at edge N gives `tx_tvalid_o` = 1 in cycle N+1.
- `prescale_o` changes at the edge following a PRESC write.
- `irq_o` updates one cycle after any cause changes.

## Configuration
- `AUX_UART_IRQ_EN` defined:
  - `irq_o` <= (RXIE & RX_NEMPTY) | (TXIE & TX_EMPTY) | RX_OVR.
  - CTRL[1:0] are writable.
- `AUX_UART_IRQ_EN` undefined:
  - `irq_o` is tied 0.
  - CTRL[1:0] are read-only 0; writes to them are ignored.
  - No IRQ flop is synthesised.

## Structure
- Package `aux_uart_pkg` holds:
  - Register offsets: `REG_DATA`=0, `REG_STATUS`=1, `REG_CTRL`=2, `REG_PRESC_LO`=3, `REG_PRESC_HI`=4.
  - STATUS and CTRL bit indices.
- Sub-module `sync_fifo`, parametrised by width 8 and FIFO_DEPTH_LOG2, instantiated twice (TX, RX).
- Flush is a synchronous clear input on `sync_fifo`.

## Test plan
- Reset, then read window: STATUS = 8'h04, CTRL = 0, PRESC_LO/HI = DEFAULT_PRESCALE bytes, `tx_tvalid_o` = 0, `irq_o` = 0.
- Write 0x41, 0x42 to DATA with `tx_tready_i` = 0, then release `tx_tready_i`: `tx_tdata_o` outputs 0x41 then 0x42, after which TX_EMPTY = 1.
- Push 17 RX bytes at depth 16 with no reads: RX_FULL = 1, RX_OVR = 1, first 16 bytes read back in order. Writing 8'h10 to STATUS clears RX_OVR.
- Full RX FIFO with a CPU DATA read and `rx_tvalid_i` in the same cycle: no overrun, count remains 16, byte order preserved.
- Write 0x34 to PRESC_LO and 0x12 to PRESC_HI: `prescale_o` = 16'h1234 one edge after the second write. CTRL write 8'h80 on a non-empty RX FIFO: RX_NEMPTY = 0 next cycle.
- With `AUX_UART_IRQ_EN` and RXIE = 1: one RX byte gives `irq_o` = 1 two edges after acceptance, then 0 after the DATA pop. Assert `reset_n` low mid-TX: `tx_tvalid_o` drops immediately.
